dmem_porta_arbiter: RTL
=======================

// Module: dmem_porta_arbiter
// PURPOSE
//  Owns dmem port a and shares it between the processor and an internal fill engine.
//  The fill engine block-writes a constant word into a dmem range, e.g. clearing the framebuffer read by the VGA controller.
//  Sits between the processor's dmem signals and dmem port a; dmem port b (VGA) is untouched.
// PARAMETERS
//  ADDR_W        12  dmem word-address width
//  DATA_W        32  dmem word width
//  PROC_MAX_WIN   4  max consecutive contended cycles the processor may win before fill gets one
// PORTS
//  clock        in   1       system clock (same clock as processor; dmem port a runs on ~clock)
//  reset        in   1       synchronous, active-high reset
//  proc_req     in   1       processor load/store valid this cycle
//  proc_addr    in   ADDR_W  processor address
//  proc_wdata   in   DATA_W  processor write data
//  proc_we      in   1       processor write enable (qualified by proc_req)
//  proc_rdata   out  DATA_W  read data to processor
//  proc_stall   out  1       processor request not granted this cycle; hold request
//  fill_start   in   1       1-cycle pulse: begin fill
//  fill_base    in   ADDR_W  first address (sampled on accepted fill_start)
//  fill_len     in   ADDR_W  word count (sampled on accepted fill_start)
//  fill_value   in   DATA_W  word to write (sampled on accepted fill_start)
//  fill_busy    out  1       fill in progress
//  fill_done    out  1       1-cycle pulse after last fill write
//  mem_addr     out  ADDR_W  -> dmem address_a
//  mem_wdata    out  DATA_W  -> dmem data_a
//  mem_we       out  1       -> dmem wren_a
//  mem_rdata    in   DATA_W  <- dmem q_a
// BEHAVIOUR
//  Reset: FSM=IDLE, fill_busy=0, fill_done=0, win counter=0, all fill regs=0; mem_we=0 in reset cycle.
//  FSM: IDLE -> (fill_start, fill_len!=0) FILL -> (last word written) DONE -> IDLE.
//   IDLE + fill_start + fill_len==0: go to DONE directly, no writes, fill_done pulses next cycle.
//   fill_start while FILL/DONE: ignored, no latching.
//  Grant (combinational, each cycle): proc only -> proc; fill only (FILL) -> fill;
//   both: proc wins unless win counter == PROC_MAX_WIN, then fill wins.
//   Win counter: +1 when proc wins a contended cycle; cleared when fill wins or no contention.
//  proc_stall = proc_req & ~proc_grant (combinational, same cycle).
//  Mem mux: proc grant -> proc_addr/proc_wdata/proc_req&proc_we; fill grant -> cur_addr/value/1; none -> mem_we=0.
//  proc_rdata = mem_rdata passthrough; valid in the granted cycle (port a clocked on ~clock).
//  Fill: one write per granted cycle; cur_addr increments modulo 2^ADDR_W (4095 -> 0 wraps);
//   remaining count decrements; on write with remaining==1 go to DONE. fill_busy=1 in FILL only.
//  fill_done high exactly one cycle (DONE state), fill_busy=0 in that cycle.
//  Reset mid-fill: abort immediately, no further writes, no fill_done pulse.
//  Never issue mem_we for both sources in one cycle; never stall proc when fill idle.
// STRUCTURE
//  Shared package/header: ADDR_W/DATA_W defaults, FSM state encodings (IDLE/FILL/DONE).
//  Sub-module: dmem_fill_engine (FSM, counters, addr gen); arbiter mux + win counter in top.
// TESTING
//  Reset: hold reset 3 cycles -> fill_busy=0, fill_done=0, mem_we=0, proc_stall=0.
//  Fill only: base=0x100, len=4, value=0xDEADBEEF -> writes 0x100..0x103 on 4 consecutive cycles, fill_done 1 cycle later.
//  Contention: proc_req held high, fill len=3, PROC_MAX_WIN=4 -> proc wins 4, fill 1, repeating; proc_stall on fill cycles only; 3 fill writes total.
//  Wrap: base=0xFFE, len=4 -> writes at 0xFFE,0xFFF,0x000,0x001.
//  Edge: len=0 -> no mem_we, fill_done next cycle; fill_start during FILL ignored (write count unchanged).
//  Reset after 2 of 8 fill writes -> no further writes, no fill_done, proc access granted next cycle.

Source files
------------

// File: rtl/dmem_porta_arbiter_pkg.sv
// Shared widths and fill-engine state encodings for the dmem port a arbiter.
package dmem_porta_arbiter_pkg;
  localparam int ADDR_W_DEF       = 12;
  localparam int DATA_W_DEF       = 32;
  localparam int PROC_MAX_WIN_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/dmem_fill_engine.sv
// Block-fill FSM: latches base/len/value on start, emits one write per granted cycle.
// Latency: first write request the cycle after start; done pulses the cycle after the last write.
module dmem_fill_engine
  import dmem_porta_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] value,
  input  logic              grant,
  output logic              fill_req,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done
);
  logic [1:0]        state;
  logic [ADDR_W-1:0] remaining;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      cur_addr   <= '0;
      remaining  <= '0;
      fill_value <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cur_addr   <= base;
            remaining  <= len;
            fill_value <= value;
            state      <= (len == '0) ? ST_DONE : ST_FILL;
          end
        end
        ST_FILL: begin
          // address wraps naturally at 2^ADDR_W
          if (grant) begin
            cur_addr  <= cur_addr + ADDR_W'(1);
            remaining <= remaining - ADDR_W'(1);
            if (remaining == ADDR_W'(1)) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fill_req = (state == ST_FILL);
  assign busy     = (state == ST_FILL);
  assign done     = (state == ST_DONE);
endmodule

// File: rtl/dmem_porta_arbiter.sv
// Shares dmem port a between the processor and the fill engine; processor has priority,
// but after PROC_MAX_WIN consecutive contended wins the fill engine gets one cycle.
module dmem_porta_arbiter
  import dmem_porta_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int PROC_MAX_WIN = PROC_MAX_WIN_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              proc_req,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  input  logic              proc_we,
  output logic [DATA_W-1:0] proc_rdata,
  output logic              proc_stall,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W-1:0] fill_len,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int WIN_W = $clog2(PROC_MAX_WIN + 1);

  logic              fill_req;
  logic              fill_act;
  logic              contended;
  logic              proc_grant;
  logic              fill_grant;
  logic [WIN_W-1:0]  win_cnt;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_word;

  dmem_fill_engine #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fill (
    .clock      (clock),
    .reset      (reset),
    .start      (fill_start),
    .base       (fill_base),
    .len        (fill_len),
    .value      (fill_value),
    .grant      (fill_grant),
    .fill_req   (fill_req),
    .cur_addr   (fill_addr),
    .fill_value (fill_word),
    .busy       (fill_busy),
    .done       (fill_done)
  );

  // a fill interrupted by reset must not reach the memory in the reset cycle
  assign fill_act   = fill_req & ~reset;
  assign contended  = proc_req & fill_act;
  assign proc_grant = proc_req & ~(contended & (win_cnt == WIN_W'(PROC_MAX_WIN)));
  assign fill_grant = fill_act & ~proc_grant;
  assign proc_stall = proc_req & ~proc_grant;
  assign proc_rdata = mem_rdata;

  always_ff @(posedge clock) begin
    if (reset)                       win_cnt <= '0;
    else if (contended & proc_grant) win_cnt <= win_cnt + WIN_W'(1);
    else                             win_cnt <= '0;
  end

  always_comb begin
    mem_addr  = proc_addr;
    mem_wdata = proc_wdata;
    mem_we    = 1'b0;
    if (fill_grant) begin
      mem_addr  = fill_addr;
      mem_wdata = fill_word;
      mem_we    = 1'b1;
    end else if (proc_grant) begin
      mem_we = proc_we;
    end
    if (reset) mem_we = 1'b0;
  end
endmodule
